fifo_access_ctrl: RTL and testbench

//  Front-end controller for the 16-entry synchronous FIFO. Shares its write port among NUM_REQ

---
 rtl/fifo_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_fifo_access_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_ctrl.sv
// Front-end controller for a 16-entry synchronous FIFO: round-robin write arbitration among
// NUM_REQ requesters, a single read consumer and a draining flush, all tracked by a private level.
module fifo_access_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int CAP     = 15,
    parameter int LVL_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_ack,
    input  logic                      rd_req,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      flush,
    output logic                      fifo_we,
    output logic                      fifo_re,
    output logic [DATA_W-1:0]         fifo_din,
    input  logic [DATA_W-1:0]         fifo_dout,
    output logic [LVL_W-1:0]          level,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 PW1       = PTR_W + 1;
    localparam logic [PTR_W:0]     NUM_REQ_X = PW1'(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]   ONE_P     = PTR_W'(1);
    localparam logic [LVL_W-1:0]   CAP_L     = LVL_W'(CAP);
    localparam logic [LVL_W-1:0]   ONE_L     = LVL_W'(1);
    localparam logic [NUM_REQ-1:0] ONE_R     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     idx_x;
    logic               win_found;
    logic [NUM_REQ-1:0] eligible;
    logic               wr_issue;
    logic               rd_issue;
    logic               re_flush;
    logic [LVL_W-1:0]   level_next;

    // Handshake: a requester holds wr_req and its data until it sees the one-cycle wr_ack pulse;
    // the data is captured on the edge that raises wr_ack. rd_valid qualifies rd_data for one cycle.
    always_comb begin
        eligible  = wr_req & ~wr_ack;
        win_found = 1'b0;
        winner    = '0;
        idx_x     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_x = {1'b0, rr_ptr} + PW1'(k);
            if (idx_x >= NUM_REQ_X) begin
                idx_x = idx_x - NUM_REQ_X;
            end
            if (!win_found && eligible[idx_x[PTR_W-1:0]]) begin
                win_found = 1'b1;
                winner    = idx_x[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        wr_issue   = 1'b0;
        rd_issue   = 1'b0;
        state_next = state;
        if (flush && (state != FLUSH)) begin
            state_next = FLUSH;
        end else begin
            case (state)
                IDLE: begin
                    wr_issue = win_found && (level < CAP_L);
                end
                RUN: begin
                    wr_issue = win_found && (level < CAP_L);
                    rd_issue = rd_req && (level != '0);
                end
                FLUSH: begin
                    rd_issue = (level != '0);
                end
                default: ;
            endcase
        end

        level_next = level;
        if (wr_issue && !rd_issue) begin
            level_next = level + ONE_L;
        end else if (!wr_issue && rd_issue) begin
            level_next = level - ONE_L;
        end

        if (!(flush && (state != FLUSH))) begin
            case (state)
                IDLE:    if (wr_issue) state_next = RUN;
                RUN:     if (!wr_issue && (level_next == '0)) state_next = IDLE;
                FLUSH:   if (level_next == '0) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // re_flush marks reads issued by the drain so their returning word is never presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            level    <= '0;
            rr_ptr   <= '0;
            wr_ack   <= '0;
            fifo_we  <= 1'b0;
            fifo_re  <= 1'b0;
            fifo_din <= '0;
            rd_valid <= 1'b0;
            re_flush <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            level    <= level_next;
            busy     <= (state_next == FLUSH);
            fifo_we  <= wr_issue;
            fifo_re  <= rd_issue;
            re_flush <= rd_issue && (state == FLUSH);
            rd_valid <= fifo_re && !re_flush && !flush;
            if (wr_issue) begin
                wr_ack   <= ONE_R << winner;
                fifo_din <= wr_data[int'(winner)*DATA_W +: DATA_W];
                rr_ptr   <= (winner == LAST_REQ) ? '0 : winner + ONE_P;
            end else begin
                wr_ack   <= '0;
            end
        end
    end

    assign rd_data   = fifo_dout;
    assign state_dbg = state;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural FIFO, write/read scoreboards, a round-robin vector
// table and directed sequences for full, read latency, flush and reset.
module tb_fifo_access_ctrl;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int LW = 4;
    localparam logic [31:0] ST_IDLE  = 32'd0;
    localparam logic [31:0] ST_RUN   = 32'd1;
    localparam logic [31:0] ST_FLUSH = 32'd2;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    wr_req;
    logic [NR*DW-1:0] wr_data;
    logic [NR-1:0]    wr_ack;
    logic             rd_req;
    logic             rd_valid;
    logic [DW-1:0]    rd_data;
    logic             flush;
    logic             fifo_we;
    logic             fifo_re;
    logic [DW-1:0]    fifo_din;
    logic [DW-1:0]    fifo_dout;
    logic [LW-1:0]    level;
    logic             busy;
    logic [1:0]       state_dbg;

    int n_checks;
    int n_errors;

    logic [NR+DW-1:0] wr_exp_q[$];
    logic [DW-1:0]    rd_exp_q[$];
    logic [DW-1:0]    fmem[$];
    logic [NR+DW-1:0] mon_e;
    logic [DW-1:0]    mon_d;
    logic [DW-1:0]    fm_tmp;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] exp_ack;
        logic [LW-1:0] exp_level;
    } vec_t;
    vec_t vecs[8];

    fifo_access_ctrl #(.NUM_REQ(NR), .DATA_W(DW), .CAP(15), .LVL_W(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .flush     (flush),
        .fifo_we   (fifo_we),
        .fifo_re   (fifo_re),
        .fifo_din  (fifo_din),
        .fifo_dout (fifo_dout),
        .level     (level),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural FIFO: registered DataOut, read before write on a shared edge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmem.delete();
            fifo_dout <= '0;
        end else begin
            if (fifo_re && (fmem.size() > 0)) begin
                fm_tmp = fmem.pop_front();
                fifo_dout <= fm_tmp;
            end
            if (fifo_we) fmem.push_back(fifo_din);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event with no expectation pending", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        wr_data[i*DW +: DW] = d;
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic expect_write(input logic [NR-1:0] ack, input logic [DW-1:0] d);
        wr_exp_q.push_back({ack, d});
        rd_exp_q.push_back(d);
    endtask

    task automatic drain(input int max_cyc);
        rd_req = 1'b1;
        for (int c = 0; (c < max_cyc) && (level != '0); c++) tick();
        rd_req = 1'b0;
        check("drain_level", 32'(level), 32'd0);
        repeat (3) tick();
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            if (fifo_we) begin
                if (wr_exp_q.size() == 0) begin
                    fail_msg("wr_unexpected");
                end else begin
                    mon_e = wr_exp_q.pop_front();
                    check("sb_wr_ack", 32'(wr_ack), 32'(mon_e[NR+DW-1:DW]));
                    check("sb_wr_din", 32'(fifo_din), 32'(mon_e[DW-1:0]));
                end
            end else if (wr_ack != '0) begin
                fail_msg("ack_without_we");
            end
            if (rd_valid) begin
                if (rd_exp_q.size() == 0) begin
                    fail_msg("rd_unexpected");
                end else begin
                    mon_d = rd_exp_q.pop_front();
                    check("sb_rd_data", 32'(rd_data), 32'(mon_d));
                end
            end
        end
    end

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ack"},   32'(wr_ack),    32'd0);
        check({pfx, "_we"},    32'(fifo_we),   32'd0);
        check({pfx, "_re"},    32'(fifo_re),   32'd0);
        check({pfx, "_rdv"},   32'(rd_valid),  32'd0);
        check({pfx, "_busy"},  32'(busy),      32'd0);
        check({pfx, "_din"},   32'(fifo_din),  32'd0);
        check({pfx, "_level"}, 32'(level),     32'd0);
        check({pfx, "_state"}, 32'(state_dbg), ST_IDLE);
    endtask

    int  cyc;
    int  acks;
    int  re_cnt;
    int  extra;
    int  w;
    logic rdv_seen;
    logic consec;
    logic prev_we;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        wr_req   = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        flush    = 1'b0;

        vecs[0] = '{req: 4'b0100, exp_ack: 4'b0100, exp_level: 4'd1};
        vecs[1] = '{req: 4'b0011, exp_ack: 4'b0001, exp_level: 4'd2};
        vecs[2] = '{req: 4'b1001, exp_ack: 4'b1000, exp_level: 4'd3};
        vecs[3] = '{req: 4'b0110, exp_ack: 4'b0010, exp_level: 4'd4};
        vecs[4] = '{req: 4'b0010, exp_ack: 4'b0010, exp_level: 4'd5};
        vecs[5] = '{req: 4'b1111, exp_ack: 4'b0100, exp_level: 4'd6};
        vecs[6] = '{req: 4'b0000, exp_ack: 4'b0000, exp_level: 4'd6};
        vecs[7] = '{req: 4'b1000, exp_ack: 4'b1000, exp_level: 4'd7};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset_n = 1'b1;
        tick();

        // Round-robin with all four requesting, each dropping after its ack
        for (int i = 0; i < NR; i++) begin
            set_data(i, DW'(16'h1100 + i));
            expect_write(oh(i), DW'(16'h1100 + i));
        end
        wr_req = '1;
        cyc = 0;
        while ((wr_req != '0) && (cyc < 10)) begin
            tick();
            cyc++;
            for (int i = 0; i < NR; i++) if (wr_ack[i]) wr_req[i] = 1'b0;
        end
        check("t2_cycles", 32'(cyc), 32'd4);
        check("t2_level", 32'(level), 32'd4);
        check("t2_state", 32'(state_dbg), ST_RUN);
        drain(20);
        check("t2_idle", 32'(state_dbg), ST_IDLE);

        // Table of single-cycle request patterns
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NR; i++) set_data(i, DW'(16'h2000 + v*16 + i));
            wr_req = vecs[v].req;
            if (vecs[v].exp_ack != '0) begin
                w = 0;
                for (int i = 0; i < NR; i++) if (vecs[v].exp_ack[i]) w = i;
                expect_write(vecs[v].exp_ack, DW'(16'h2000 + v*16 + w));
            end
            tick();
            check($sformatf("vec%0d_ack", v), 32'(wr_ack), 32'(vecs[v].exp_ack));
            check($sformatf("vec%0d_level", v), 32'(level), 32'(vecs[v].exp_level));
            wr_req = '0;
            tick();
            check($sformatf("vec%0d_ack_clr", v), 32'(wr_ack), 32'd0);
        end

        // Flush at level 7 with a coincident write request
        check("t6_pre_level", 32'(level), 32'd7);
        rd_exp_q.delete();
        flush  = 1'b1;
        wr_req = oh(0);
        set_data(0, 16'hDEAD);
        tick();
        flush  = 1'b0;
        wr_req = '0;
        check("t6_ack", 32'(wr_ack), 32'd0);
        check("t6_we", 32'(fifo_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_state", 32'(state_dbg), ST_FLUSH);
        check("t6_level_hold", 32'(level), 32'd7);
        cyc = 0;
        re_cnt = 0;
        rdv_seen = 1'b0;
        while (busy && (cyc < 20)) begin
            tick();
            cyc++;
            if (fifo_re) re_cnt++;
            if (rd_valid) rdv_seen = 1'b1;
        end
        repeat (2) begin
            tick();
            if (fifo_re) re_cnt++;
            if (rd_valid) rdv_seen = 1'b1;
        end
        check("t6_busy_cycles", 32'(cyc), 32'd7);
        check("t6_re_count", 32'(re_cnt), 32'd7);
        check("t6_rd_valid", 32'(rdv_seen), 32'd0);
        check("t6_level", 32'(level), 32'd0);
        check("t6_state_end", 32'(state_dbg), ST_IDLE);

        // One requester held: no back-to-back grants
        set_data(2, 16'h3333);
        repeat (3) expect_write(oh(2), 16'h3333);
        wr_req  = oh(2);
        acks    = 0;
        consec  = 1'b0;
        prev_we = 1'b0;
        repeat (6) begin
            tick();
            if (wr_ack[2]) acks++;
            if (fifo_we && prev_we) consec = 1'b1;
            prev_we = fifo_we;
        end
        wr_req = '0;
        tick();
        check("t3_acks", 32'(acks), 32'd3);
        check("t3_consec_we", 32'(consec), 32'd0);
        check("t3_level", 32'(level), 32'd3);
        drain(20);

        // Fill to capacity, then free one slot
        set_data(0, 16'h4000);
        expect_write(oh(0), 16'h4000);
        wr_req = oh(0);
        acks = 0;
        cyc  = 0;
        while ((acks < 15) && (cyc < 60)) begin
            tick();
            cyc++;
            if (wr_ack[0]) begin
                acks++;
                set_data(0, DW'(16'h4000 + acks));
                expect_write(oh(0), DW'(16'h4000 + acks));
            end
        end
        check("t4_acks", 32'(acks), 32'd15);
        check("t4_level_full", 32'(level), 32'd15);
        extra = 0;
        repeat (4) begin
            tick();
            if (wr_ack != '0) extra++;
        end
        check("t4_no_ack_full", 32'(extra), 32'd0);
        check("t4_level_hold", 32'(level), 32'd15);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t4_level_14", 32'(level), 32'd14);
        check("t4_no_ack_same", 32'(wr_ack), 32'd0);
        check("t4_re", 32'(fifo_re), 32'd1);
        tick();
        check("t4_ack_after", 32'(wr_ack), 32'(oh(0)));
        check("t4_level_refill", 32'(level), 32'd15);
        wr_req = '0;
        drain(40);

        // Read latency from an empty FIFO
        set_data(0, 16'hA5A5);
        expect_write(oh(0), 16'hA5A5);
        wr_req = oh(0);
        tick();
        wr_req = '0;
        check("t5_we", 32'(fifo_we), 32'd1);
        check("t5_din", 32'(fifo_din), 32'hA5A5);
        check("t5_level1", 32'(level), 32'd1);
        check("t5_state_run", 32'(state_dbg), ST_RUN);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_re", 32'(fifo_re), 32'd1);
        check("t5_rdv_early", 32'(rd_valid), 32'd0);
        check("t5_level0", 32'(level), 32'd0);
        check("t5_state_idle", 32'(state_dbg), ST_IDLE);
        tick();
        check("t5_rdv", 32'(rd_valid), 32'd1);
        check("t5_rd_data", 32'(rd_data), 32'hA5A5);
        check("t5_re_off", 32'(fifo_re), 32'd0);
        tick();
        check("t5_rdv_off", 32'(rd_valid), 32'd0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < NR; i++) set_data(i, DW'(16'h5500 + i));
        expect_write(oh(1), 16'h5501);
        expect_write(oh(2), 16'h5502);
        wr_req = '1;
        repeat (2) begin
            tick();
            for (int i = 0; i < NR; i++) if (wr_ack[i]) wr_req[i] = 1'b0;
        end
        check("mid_level_pre", 32'(level), 32'd2);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        wr_req  = '0;
        #1;
        check_all_zero("mid");
        check("mid_wr_q", 32'(wr_exp_q.size()), 32'd0);
        wr_exp_q.delete();
        rd_exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_level", 32'(level), 32'd0);
        check("post_rst_we", 32'(fifo_we), 32'd0);

        check("final_wr_q", 32'(wr_exp_q.size()), 32'd0);
        check("final_rd_q", 32'(rd_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
